// File: rtl/pipeline_run_ctrl.sv
// Run controller for the 4-stage pipeline: owns pc, imem write port and run/drain sequencing.
// Optional single-step run mode enabled by defining PIPE_CTRL_STEP_EN.
module pipeline_run_ctrl #(
    parameter int unsigned IMEM_DEPTH   = 16,
    parameter int unsigned RUN_LEN      = 16,
    parameter int unsigned DRAIN_CYCLES = 3,
    localparam int unsigned AW          = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          halt_req,
`ifdef PIPE_CTRL_STEP_EN
    input  logic          step,
`endif
    input  logic          load_valid,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    output logic          load_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [7:0]    imem_wdata,
    output logic [AW-1:0] pc,
    output logic          fetch_valid,
    output logic          pipe_en,
    output logic          flush,
    output logic          busy,
    output logic          done,
    output logic [7:0]    issued_cnt
);

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e        state;
    state_e        next_state;
    logic [CW-1:0] run_cnt;
    logic [DW-1:0] drain_cnt;
    logic [CW-1:0] run_last;
    logic          launch_c;
    logic          load_acc_c;

    // Effective last run-counter value; a single-step run stops after the first fetch
`ifdef PIPE_CTRL_STEP_EN
    logic step_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_mode <= 1'b0;
        end else if (launch_c) begin
            step_mode <= ~start;
        end
    end

    assign run_last = step_mode ? '0 : CW'(RUN_LEN - 1);
`else
    assign run_last = CW'(RUN_LEN - 1);
`endif

    assign launch_c   = ((state == IDLE) || (state == DONE)) && (next_state == CLEAR);
    assign load_acc_c = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = CLEAR;
                end
`ifdef PIPE_CTRL_STEP_EN
                else if (step) begin
                    next_state = CLEAR;
                end
`endif
            end
            CLEAR: next_state = RUN;
            RUN: begin
                if (halt_req || (run_cnt == run_last)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Control outputs are registered copies of the state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush       <= 1'b0;
            pipe_en     <= 1'b0;
            fetch_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_ready  <= 1'b1;
        end else begin
            flush       <= (next_state == CLEAR);
            pipe_en     <= (next_state == CLEAR) || (next_state == RUN) || (next_state == DRAIN);
            fetch_valid <= (next_state == RUN);
            busy        <= (next_state == CLEAR) || (next_state == RUN) || (next_state == DRAIN);
            done        <= (next_state == DONE);
            load_ready  <= (next_state == IDLE) || (next_state == DONE);
        end
    end

    // Counters are zeroed on the edge into CLEAR so CLEAR already shows a clean run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            issued_cnt <= '0;
            run_cnt    <= '0;
            drain_cnt  <= '0;
        end else if (launch_c) begin
            pc         <= '0;
            issued_cnt <= '0;
            run_cnt    <= '0;
            drain_cnt  <= '0;
        end else if (state == RUN) begin
            pc      <= pc + AW'(1);
            run_cnt <= run_cnt + CW'(1);
            if (issued_cnt != '1) begin
                issued_cnt <= issued_cnt + CW'(1);
            end
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + DW'(1);
        end
    end

    // Accepted load beat becomes a one-cycle registered write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= load_acc_c;
            if (load_acc_c) begin
                imem_waddr <= load_addr;
                imem_wdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl: two instances (RUN_LEN 16 and 20) share all inputs.
module tb_pipeline_run_ctrl;

    localparam logic [5:0] S_IDLE  = 6'b000001;
    localparam logic [5:0] S_CLEAR = 6'b110100;
    localparam logic [5:0] S_RUN   = 6'b011100;
    localparam logic [5:0] S_DRAIN = 6'b010100;
    localparam logic [5:0] S_DONE  = 6'b000011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, halt_req, step, load_valid;
    logic [3:0] load_addr;
    logic [7:0] load_data;

    logic       load_ready_w [2];
    logic       imem_we_w    [2];
    logic [3:0] imem_waddr_w [2];
    logic [7:0] imem_wdata_w [2];
    logic [3:0] pc_w         [2];
    logic       fetch_valid_w[2];
    logic       pipe_en_w    [2];
    logic       flush_w      [2];
    logic       busy_w       [2];
    logic       done_w       [2];
    logic [7:0] issued_w     [2];
    logic [5:0] st_w         [2];

    int vectors;
    int miscompares;
    int run_len [2] = '{16, 20};

    always #5 clk = ~clk;

    pipeline_run_ctrl #(.IMEM_DEPTH(16), .RUN_LEN(16), .DRAIN_CYCLES(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
`ifdef PIPE_CTRL_STEP_EN
        .step(step),
`endif
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready_w[0]), .imem_we(imem_we_w[0]), .imem_waddr(imem_waddr_w[0]),
        .imem_wdata(imem_wdata_w[0]), .pc(pc_w[0]), .fetch_valid(fetch_valid_w[0]),
        .pipe_en(pipe_en_w[0]), .flush(flush_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .issued_cnt(issued_w[0])
    );

    pipeline_run_ctrl #(.IMEM_DEPTH(16), .RUN_LEN(20), .DRAIN_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
`ifdef PIPE_CTRL_STEP_EN
        .step(step),
`endif
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready_w[1]), .imem_we(imem_we_w[1]), .imem_waddr(imem_waddr_w[1]),
        .imem_wdata(imem_wdata_w[1]), .pc(pc_w[1]), .fetch_valid(fetch_valid_w[1]),
        .pipe_en(pipe_en_w[1]), .flush(flush_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .issued_cnt(issued_w[1])
    );

    // Status word: {flush, pipe_en, fetch_valid, busy, done, load_ready}
    assign st_w[0] = {flush_w[0], pipe_en_w[0], fetch_valid_w[0], busy_w[0], done_w[0], load_ready_w[0]};
    assign st_w[1] = {flush_w[1], pipe_en_w[1], fetch_valid_w[1], busy_w[1], done_w[1], load_ready_w[1]};

    // Expected values t cycles after entering CLEAR, DRAIN_CYCLES = 3
    function automatic logic [5:0] exp_st(input int t, input int len);
        if (t == 0) return S_CLEAR;
        if (t <= len) return S_RUN;
        if (t <= len + 3) return S_DRAIN;
        return S_DONE;
    endfunction

    function automatic logic [3:0] exp_pc(input int t, input int len);
        if (t == 0) return 4'd0;
        if (t <= len) return 4'((t - 1) % 16);
        return 4'(len % 16);
    endfunction

    function automatic logic [7:0] exp_iss(input int t, input int len);
        if (t == 0) return 8'd0;
        if (t <= len) return 8'(t - 1);
        return 8'(len);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (st_w[d] !== S_IDLE || pc_w[d] !== 4'd0 || issued_w[d] !== 8'd0 ||
                imem_we_w[d] !== 1'b0 || imem_waddr_w[d] !== 4'd0 || imem_wdata_w[d] !== 8'd0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: st=%b pc=%0d iss=%0d we=%b wa=%0d wd=%h, want st=%b zeros",
                         d, st_w[d], pc_w[d], issued_w[d], imem_we_w[d], imem_waddr_w[d], imem_wdata_w[d], S_IDLE);
            end
        end
        rst_n = 1'b1;
        load_valid = 1'b1; load_addr = 4'd7; load_data = 8'hAA;
        tick();
        load_valid = 1'b0;
        vectors++;
        if (imem_we_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL pend_write_pre: we=%b want 1", imem_we_w[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (imem_we_w[d] !== 1'b0 || imem_waddr_w[d] !== 4'd0 || imem_wdata_w[d] !== 8'd0) begin
                miscompares++;
                $display("FAIL pend_write_drop dut%0d: we=%b wa=%0d wd=%h want 0/0/00",
                         d, imem_we_w[d], imem_waddr_w[d], imem_wdata_w[d]);
            end
        end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        logic [7:0] tbl [4] = '{8'h05, 8'h16, 8'h27, 8'h38};
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_addr = 4'(i); load_data = tbl[i];
            tick();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (imem_we_w[d] !== 1'b1 || imem_waddr_w[d] !== 4'(i) || imem_wdata_w[d] !== tbl[i]) begin
                    miscompares++;
                    $display("FAIL load_beat%0d dut%0d: we=%b wa=%0d wd=%h want 1/%0d/%h",
                             i, d, imem_we_w[d], imem_waddr_w[d], imem_wdata_w[d], i, tbl[i]);
                end
            end
        end
        load_valid = 1'b0;
        tick();
        vectors++;
        if (imem_we_w[0] !== 1'b0 || st_w[0] !== S_IDLE) begin
            miscompares++;
            $display("FAIL load_end: we=%b st=%b want 0/%b", imem_we_w[0], st_w[0], S_IDLE);
        end
    endtask

    // Full runs on both instances, with a load accepted together with start
    task automatic test_run();
        start = 1'b1; load_valid = 1'b1; load_addr = 4'd4; load_data = 8'h49;
        tick();
        start = 1'b0; load_valid = 1'b0;
        for (int t = 0; t <= 24; t++) begin
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (st_w[d] !== exp_st(t, run_len[d]) || pc_w[d] !== exp_pc(t, run_len[d]) ||
                    issued_w[d] !== exp_iss(t, run_len[d])) begin
                    miscompares++;
                    $display("FAIL run_t%0d dut%0d: st=%b pc=%0d iss=%0d want st=%b pc=%0d iss=%0d",
                             t, d, st_w[d], pc_w[d], issued_w[d],
                             exp_st(t, run_len[d]), exp_pc(t, run_len[d]), exp_iss(t, run_len[d]));
                end
                vectors++;
                if (t == 0 && (imem_we_w[d] !== 1'b1 || imem_waddr_w[d] !== 4'd4 || imem_wdata_w[d] !== 8'h49)) begin
                    miscompares++;
                    $display("FAIL start_load dut%0d: we=%b wa=%0d wd=%h want 1/4/49",
                             d, imem_we_w[d], imem_waddr_w[d], imem_wdata_w[d]);
                end else if (t >= 1 && t <= 11 && imem_we_w[d] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy_load t%0d dut%0d: we=%b want 0", t, d, imem_we_w[d]);
                end
            end
            if (t == 0) load_valid = 1'b1;
            if (t == 10) load_valid = 1'b0;
            tick();
        end
    endtask

    // Halt in the 6th RUN cycle; start in RUN and DRAIN must be ignored
    task automatic test_halt();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 1; k <= 6; k++) begin
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (st_w[d] !== S_RUN || pc_w[d] !== 4'(k - 1)) begin
                    miscompares++;
                    $display("FAIL halt_run%0d dut%0d: st=%b pc=%0d want %b/%0d", k, d, st_w[d], pc_w[d], S_RUN, k - 1);
                end
            end
            start = (k == 3);
            halt_req = (k == 6);
            tick();
        end
        start = 1'b0; halt_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (st_w[d] !== ((j < 3) ? S_DRAIN : S_DONE) || issued_w[d] !== 8'd6 || pc_w[d] !== 4'd6) begin
                    miscompares++;
                    $display("FAIL halt_tail%0d dut%0d: st=%b iss=%0d pc=%0d want %b/6/6",
                             j, d, st_w[d], issued_w[d], pc_w[d], (j < 3) ? S_DRAIN : S_DONE);
                end
            end
            start = (j == 0);
            halt_req = (j == 3);
            tick();
        end
        start = 1'b0; halt_req = 1'b0;
        vectors++;
        if (st_w[0] !== S_DONE || st_w[1] !== S_DONE) begin
            miscompares++;
            $display("FAIL no_queue: st=%b/%b want %b", st_w[0], st_w[1], S_DONE);
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        vectors++;
        if (pc_w[0] !== 4'd5 || st_w[0] !== S_RUN) begin
            miscompares++;
            $display("FAIL pre_reset: pc=%0d st=%b want 5/%b", pc_w[0], st_w[0], S_RUN);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (pc_w[d] !== 4'd0 || st_w[d] !== S_IDLE || issued_w[d] !== 8'd0) begin
                miscompares++;
                $display("FAIL mid_reset dut%0d: pc=%0d st=%b iss=%0d want 0/%b/0", d, pc_w[d], st_w[d], issued_w[d], S_IDLE);
            end
        end
        #1 rst_n = 1'b1;
        tick();
        vectors++;
        if (st_w[0] !== S_IDLE || st_w[1] !== S_IDLE) begin
            miscompares++;
            $display("FAIL post_reset: st=%b/%b want %b", st_w[0], st_w[1], S_IDLE);
        end
    endtask

`ifdef PIPE_CTRL_STEP_EN
    task automatic test_step();
        logic [5:0] seq [6] = '{S_CLEAR, S_RUN, S_DRAIN, S_DRAIN, S_DRAIN, S_DONE};
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int t = 0; t < 6; t++) begin
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (st_w[d] !== seq[t] || pc_w[d] !== ((t <= 1) ? 4'd0 : 4'd1) ||
                    issued_w[d] !== ((t <= 1) ? 8'd0 : 8'd1)) begin
                    miscompares++;
                    $display("FAIL step_t%0d dut%0d: st=%b pc=%0d iss=%0d want %b", t, d, st_w[d], pc_w[d], issued_w[d], seq[t]);
                end
            end
            tick();
        end
    endtask
`endif

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; step = 1'b0;
        load_valid = 1'b0; load_addr = '0; load_data = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load();
        test_run();
        test_halt();
`ifdef PIPE_CTRL_STEP_EN
        test_step();
`endif
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
